// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM pin and the capture block's status/compare consumers.
// The master side is the capture block itself.
interface pwm_capture_if #(
  parameter int CBITS = 16
);
  logic             pwm_in;
  logic [CBITS:0]   period_out;
  logic [CBITS:0]   high_out;
  logic [2:0]       duty_code;
  logic             valid;
  logic             stuck;
  logic             stuck_level;

  modport master (
    input  pwm_in,
    output period_out, high_out, duty_code, valid, stuck, stuck_level
  );

  modport slave (
    output pwm_in,
    input  period_out, high_out, duty_code, valid, stuck, stuck_level
  );
endinterface

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in clk cycles,
// recovers the generator duty code and flags a line with no rising edges.
//
//   state   | meaning
//   IDLE    | no reference rise yet (after reset or stuck); partial period discarded
//   MEASURE | last rise seen; next rise publishes period/high
module pwm_capture #(
  parameter int CBITS = 16
) (
  input logic           clk,
  input logic           rst,
  pwm_capture_if.master bus
);

  localparam logic [CBITS:0] CNT_MAX = '1;
  localparam logic [CBITS:0] CNT_PRE = CNT_MAX - 1'b1;
  localparam logic [CBITS:0] CNT_ONE = {{CBITS{1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t         state;
  state_t         state_next;
  logic           s1;
  logic           s2;
  logic           s3;
  logic           rise;
  logic           hit_max;
  logic           capture;
  logic [CBITS:0] period_cnt;
  logic [CBITS:0] high_cnt;

  assign rise    = s2 & ~s3;
  // Stuck fires on the cycle the period counter lands on all-ones; a rise that cycle wins.
  assign hit_max = ~rise && (period_cnt == CNT_PRE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          capture = 1'b1;
        end else if (hit_max) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1              <= 1'b0;
      s2              <= 1'b0;
      s3              <= 1'b0;
      period_cnt      <= '0;
      high_cnt        <= '0;
      bus.period_out  <= '0;
      bus.high_out    <= '0;
      bus.duty_code   <= '0;
      bus.valid       <= 1'b0;
      bus.stuck       <= 1'b0;
      bus.stuck_level <= 1'b0;
    end else begin
      s1        <= bus.pwm_in;
      s2        <= s1;
      s3        <= s2;
      bus.valid <= capture;

      if (rise) begin
        period_cnt <= CNT_ONE;
        high_cnt   <= CNT_ONE;
      end else begin
        if (period_cnt != CNT_MAX) begin
          period_cnt <= period_cnt + 1'b1;
        end
        if (s2 && (high_cnt != CNT_MAX)) begin
          high_cnt <= high_cnt + 1'b1;
        end
      end

      if (capture) begin
        bus.period_out <= period_cnt;
        bus.high_out   <= high_cnt;
        bus.duty_code  <= high_cnt[CBITS-2:CBITS-4];
        bus.stuck      <= 1'b0;
      end else if (hit_max) begin
        bus.stuck       <= 1'b1;
        bus.stuck_level <= s2;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomised and directed stimulus for pwm_capture; a pin-level model predicts each
// published period/high pair and a monitor compares them as valid strobes appear.
module tb_pwm_capture;

  localparam int CBITS   = 8;
  localparam int STUCK_P = (1 << (CBITS + 1)) - 1;

  typedef struct {
    int p;
    int h;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  pwm_capture_if #(.CBITS(CBITS)) bus ();

  pwm_capture #(.CBITS(CBITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   gap_cyc = 0;
  int   high_cyc = 0;
  bit   armed = 1'b0;
  int   last_p = 0;
  int   last_h = 0;
  bit   prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Pin-level model: a rise publishes the period since the previous rise, unless
  // there was no previous rise or the gap was long enough to be declared stuck.
  task automatic start_rise();
    exp_t e;
    if (armed && gap_cyc < STUCK_P) begin
      e.p = gap_cyc;
      e.h = high_cyc;
      exp_q.push_back(e);
      last_p = gap_cyc;
      last_h = high_cyc;
    end
    armed    = 1'b1;
    gap_cyc  = 0;
    high_cyc = 0;
  endtask

  task automatic hold(input bit lvl, input int n);
    bus.pwm_in = lvl;
    repeat (n) @(negedge clk);
    gap_cyc += n;
    if (lvl) high_cyc += n;
  endtask

  task automatic pulse(input int h, input int l);
    start_rise();
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_period_out"}, bus.period_out, 0);
    check({tag, "_high_out"}, bus.high_out, 0);
    check({tag, "_duty_code"}, bus.duty_code, 0);
    check({tag, "_valid"}, bus.valid, 0);
    check({tag, "_stuck"}, bus.stuck, 0);
    check({tag, "_stuck_level"}, bus.stuck_level, 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && bus.valid) begin
      check("valid_not_back_to_back", prev_valid, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual period=%0d high=%0d required no strobe",
                 bus.period_out, bus.high_out);
      end else begin
        e = exp_q.pop_front();
        check("period_out", bus.period_out, e.p);
        check("high_out", bus.high_out, e.h);
        check("duty_code", bus.duty_code, (e.h >> (CBITS - 4)) & 7);
        check("stuck_on_valid", bus.stuck, 0);
      end
    end
    prev_valid = bus.valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bus.pwm_in = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // line held low from reset: stuck after 2^(CBITS+1)-1 cycles
    n = 0;
    while (!bus.stuck && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("stuck_low_latency", n, STUCK_P);
    check("stuck_low_level", bus.stuck_level, 0);
    check("stuck_low_period_held", bus.period_out, 0);
    @(negedge clk);

    // 4/12 waveform: stuck survives the first rise, clears on the first valid
    pulse(4, 12);
    check("stuck_kept_first_rise", bus.stuck, 1);
    start_rise();
    hold(1'b1, 4);
    check("stuck_cleared_by_valid", bus.stuck, 0);
    hold(1'b0, 12);
    repeat (3) pulse(4, 12);

    // generator code 5: high = {0,101,1,000}
    repeat (3) pulse(8'h58, 8'hA8);

    // period change 16 -> 10
    repeat (2) pulse(4, 12);
    repeat (3) pulse(3, 7);

    // longest measurable period, then one cycle longer trips stuck
    repeat (2) pulse(5, STUCK_P - 6);
    pulse(5, STUCK_P - 5);
    start_rise();
    hold(1'b1, 5);
    check("stuck_at_boundary", bus.stuck, 1);
    check("stuck_boundary_level", bus.stuck_level, 0);
    check("stuck_boundary_period_held", bus.period_out, STUCK_P - 1);
    hold(1'b0, 20);
    repeat (2) pulse(4, 12);

    // held high after a valid period
    start_rise();
    hold(1'b1, 520);
    check("stuck_high", bus.stuck, 1);
    check("stuck_high_level", bus.stuck_level, 1);
    check("stuck_high_period_held", bus.period_out, last_p);
    check("stuck_high_high_held", bus.high_out, last_h);
    hold(1'b0, 6);
    repeat (3) pulse(4, 12);

    // reset in the middle of a period
    start_rise();
    hold(1'b1, 4);
    hold(1'b0, 6);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    armed    = 1'b0;
    gap_cyc  = 0;
    high_cyc = 0;
    repeat (3) pulse(4, 12);

    // random periods, including single-cycle glitches
    for (int i = 0; i < 40; i++) begin
      pulse($urandom_range(1, 40), $urandom_range(1, 120));
    end

    start_rise();
    hold(1'b1, 4);
    hold(1'b0, 10);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
